// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind the UART receiver: rising-edge write detect, FWFT read port,
// fill level, sticky overrun flag and saturating dropped-byte counter.
module uart_rx_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] rec_data_in,
    input  logic              rec_valid_in,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              overrun,
    input  logic              ovr_clr,
    output logic [7:0]        drop_cnt
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [7:0] DROP_MAX = 8'hFF;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overrun_q, overrun_d;
    logic [7:0]        drop_cnt_q, drop_cnt_d;

    logic push_c;
    logic pop_c;
    logic accept_c;
    logic drop_c;
    logic full_c;
    logic empty_c;

    // Status decoded from the registered count only.
    always_comb begin
        full_c  = (count_q == DEPTH_CNT);
        empty_c = (count_q == '0);
    end

    // Write detect and pop qualification; a pop on a full FIFO frees the slot for a push.
    always_comb begin
        push_c   = rec_valid_in & ~valid_q;
        pop_c    = ~empty_c & rd_ready;
        accept_c = push_c & (~full_c | pop_c);
        drop_c   = push_c & full_c & ~pop_c;
    end

    // Next-state for pointers, occupancy and overrun bookkeeping.
    always_comb begin
        valid_d    = rec_valid_in;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overrun_d  = overrun_q;
        drop_cnt_d = drop_cnt_q;

        if (accept_c) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end
        count_d = count_q + CNT_W'(accept_c) - CNT_W'(pop_c);

        // A drop in the same cycle as a clear wins and restarts the count at one.
        if (drop_c) begin
            overrun_d = 1'b1;
            if (ovr_clr) begin
                drop_cnt_d = 8'd1;
            end else if (drop_cnt_q != DROP_MAX) begin
                drop_cnt_d = drop_cnt_q + 8'd1;
            end
        end else if (ovr_clr) begin
            overrun_d  = 1'b0;
            drop_cnt_d = 8'd0;
        end
    end

    // valid_q resets high so a level held through reset is not taken as a new byte.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q    <= 1'b1;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overrun_q  <= 1'b0;
            drop_cnt_q <= 8'd0;
        end else begin
            valid_q    <= valid_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overrun_q  <= overrun_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Storage is not reset; stale contents are hidden by rd_valid.
    always_ff @(posedge clk) begin
        if (accept_c) begin
            mem_q[wr_ptr_q] <= rec_data_in;
        end
    end

    always_comb begin
        rd_data  = mem_q[rd_ptr_q];
        rd_valid = ~empty_c;
        count    = count_q;
        full     = full_c;
        empty    = empty_c;
        overrun  = overrun_q;
        drop_cnt = drop_cnt_q;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive buffer that sits directly downstream of the UART receiver (rx).
- Captures each byte rx reports on rec_data_out/rec_valid_out into a DEPTH-entry FIFO.
- Presents bytes to the host side on a first-word-fall-through valid/ready interface.
- Reports fill level, full/empty, a sticky overrun flag and a saturating dropped-byte counter.

Parameters:
DATA_W, 8, byte width; must match rx data width
DEPTH, 16, FIFO entries; power of 2, minimum 2
ADDR_W, 4, log2(DEPTH)

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  asynchronous active-low reset (rst=0 resets)
rec_data_in  input  DATA_W  byte from rx rec_data_out
rec_valid_in  input  1  rx rec_valid_out; level or pulse
rd_data  output  DATA_W  head-of-FIFO byte; meaningful only when rd_valid=1
rd_valid  output  1  FIFO non-empty
rd_ready  input  1  consumer accepts rd_data this cycle
count  output  ADDR_W+1  current occupancy, 0..DEPTH
full  output  1  count==DEPTH
empty  output  1  count==0
overrun  output  1  sticky: a byte was dropped because the FIFO was full
ovr_clr  input  1  synchronous clear of overrun and drop_cnt
drop_cnt  output  8  dropped bytes since last clear; saturates at 255

Behaviour:
Reset (rst=0, asynchronous):
- wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, rd_valid=0, overrun=0, drop_cnt=0.
- Internal valid_q=1, so a rec_valid_in held high through reset does not cause a write.
- Memory contents are not reset; rd_data is don't-care while empty.
- Reset mid-operation discards all stored bytes immediately.

Write detect:
- valid_q <= rec_valid_in every cycle.
- push = rec_valid_in & ~valid_q, i.e. rising edge only. Each rx byte is accepted exactly once, whether rx holds valid as a level or pulses it.
- rec_data_in is sampled in the same cycle push is asserted.

Pop:
- pop = rd_valid & rd_ready. rd_ready while empty has no effect.

Per-cycle update:
- push & ~full: mem[wr_ptr] <= data; wr_ptr++ (wraps modulo DEPTH).
- pop: rd_ptr++ (wraps modulo DEPTH).
- count += (push accepted) - pop.
- push & full & pop: push is accepted, since the pop frees a slot. count stays DEPTH and both pointers advance.
- push & full & ~pop: byte dropped; pointers and count unchanged; overrun <= 1; drop_cnt++ unless it is already 255.
- push & empty & rd_ready: push accepted, no pop that cycle; count becomes 1.
- ovr_clr & drop in the same cycle: set wins, so overrun=1 and drop_cnt=1.
- ovr_clr alone: overrun=0, drop_cnt=0 on the next edge.

Latency and outputs:
- A pushed byte appears on rd_data, with rd_valid=1, the cycle after the push edge (one-cycle write-to-read latency).
- FWFT: rd_data = mem[rd_ptr], combinational from registered pointer. After a pop, the next byte is presented in the following cycle with no bubble.
- full, empty and rd_valid are decoded from registered count; no combinational path from rd_ready or rec_valid_in.

Assertions the bench must check:
- count never exceeds DEPTH and never underflows.
- Byte order is preserved.
- Pointers wrap correctly at DEPTH-1 -> 0.

Test Plan:
- Reset with rec_valid_in=1 held through and after release -> no write; empty=1, count=0.
- Three rx bytes 0x55, 0xA3, 0x0F, each with rec_valid_in high for 4 cycles, rd_ready=0 -> count=3. Then rd_ready=1 -> rd_data yields 0x55, 0xA3, 0x0F on consecutive cycles, then empty=1.
- Push 16 bytes 0x00..0x0F, then 2 more (0x10, 0x11) with no reads -> full=1, overrun=1, drop_cnt=2. Read-out returns exactly 0x00..0x0F.
- Full FIFO, push 0x77 in the same cycle as a pop -> push accepted, count stays 16. The last byte read out is 0x77.
- 20 push/pop cycles straddling the wrap point -> data order preserved, count returns to 0. Then ovr_clr asserted alone -> overrun=0, drop_cnt=0. Then ovr_clr together with a drop -> overrun=1, drop_cnt=1.
- Assert rst=0 asynchronously, mid-clock, with count=5 -> outputs reset immediately. After release, the next pushed byte 0x3C is the first byte read.
